module_keypad_scan: RTL and testbench

MODULE_KEYPAD_SCAN -- requirements
Module: module_keypad_scan

---
 rtl/pkg_keypad.sv | 26 ++
 rtl/module_sync_2ff.sv | 26 ++
 rtl/module_keypad_scan.sv | 160 ++++++++++++++++
 tb/tb_module_keypad_scan.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_keypad.sv
// Shared types and constants for the 4x4 keypad scanner.
package pkg_keypad;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int KEY_W = 4;
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  typedef enum logic [2:0] {
    SCAN_DRIVE,
    SCAN_SAMPLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_e;

  // Several columns closing together resolve to the lowest-numbered column.
  function automatic logic [COL_W-1:0] lowest_col(input logic [COLS-1:0] pat);
    lowest_col = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (pat[i]) lowest_col = COL_W'(i);
    end
  endfunction

endpackage

// File: rtl/module_sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous level inputs.
module module_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/module_keypad_scan.sv
// 4x4 matrix keypad scanner: row drive, column debounce, key code handshake.
module module_keypad_scan
  import pkg_keypad::*;
#(
  parameter int SETTLE_CYCLES = 27,
  parameter int DB_CYCLES     = 270000,
  parameter int CNT_W         = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [COLS-1:0]  columnas,
  output logic [ROWS-1:0]  filas,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_code,
  input  logic             key_ack,
  output logic             key_held,
  output logic             overrun
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  generate
    if ((longint'(DB_CYCLES) > CNT_MAX) || (longint'(SETTLE_CYCLES) > CNT_MAX) ||
        (DB_CYCLES < 1) || (SETTLE_CYCLES < 1)) begin : g_bad_params
      $error("module_keypad_scan: DB_CYCLES/SETTLE_CYCLES must be in 1..2**CNT_W-1");
    end
  endgenerate

  // Terminal counts: the counter runs 0..N-1, so N cycles/samples elapse.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYCLES - 1);

  logic [COLS-1:0]  col_s;
  state_e           state_q;
  logic [ROW_W-1:0] row_q;
  logic [CNT_W-1:0] cnt_q;
  logic [COLS-1:0]  pattern_q;
  logic [ROWS-1:0]  filas_q;
  logic             key_valid_q;
  logic [KEY_W-1:0] key_code_q;
  logic             key_held_q;
  logic             overrun_q;
  logic             press_entry;

  module_sync_2ff #(
    .WIDTH (COLS)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (columnas),
    .q_o   (col_s)
  );

  // Last matching debounce sample: the FSM enters PRESSED on this edge.
  assign press_entry = (state_q == DEBOUNCE) && (col_s == pattern_q) && (cnt_q == DB_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN_DRIVE;
      row_q       <= '0;
      cnt_q       <= '0;
      pattern_q   <= '0;
      filas_q     <= ROWS'(1);
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_held_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      case (state_q)
        SCAN_DRIVE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= SCAN_SAMPLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        SCAN_SAMPLE: begin
          if (col_s == '0) begin
            row_q   <= row_q + 1'b1;
            filas_q <= {filas_q[ROWS-2:0], filas_q[ROWS-1]};
            state_q <= SCAN_DRIVE;
          end else begin
            pattern_q <= col_s;
            cnt_q     <= '0;
            state_q   <= DEBOUNCE;
          end
        end

        DEBOUNCE: begin
          if (col_s != pattern_q) begin
            cnt_q   <= '0;
            row_q   <= row_q + 1'b1;
            filas_q <= {filas_q[ROWS-2:0], filas_q[ROWS-1]};
            state_q <= SCAN_DRIVE;
          end else if (cnt_q == DB_LAST) begin
            cnt_q      <= '0;
            key_held_q <= 1'b1;
            state_q    <= PRESSED;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        PRESSED: begin
          if (col_s == '0) begin
            cnt_q   <= '0;
            state_q <= RELEASE;
          end
        end

        // Chatter during release restarts the quiet-time count without
        // reporting another key.
        RELEASE: begin
          if (col_s != '0) begin
            cnt_q <= '0;
          end else if (cnt_q == DB_LAST) begin
            cnt_q      <= '0;
            key_held_q <= 1'b0;
            row_q      <= '0;
            filas_q    <= ROWS'(1);
            state_q    <= SCAN_DRIVE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          cnt_q   <= '0;
          row_q   <= '0;
          filas_q <= ROWS'(1);
          state_q <= SCAN_DRIVE;
        end
      endcase

      if (key_ack) begin
        key_valid_q <= 1'b0;
        overrun_q   <= 1'b0;
      end

      // An ack in the same cycle frees the slot, so the new press loads.
      if (press_entry) begin
        if (key_valid_q && !key_ack) begin
          overrun_q <= 1'b1;
        end else begin
          key_valid_q <= 1'b1;
          key_code_q  <= {row_q, lowest_col(pattern_q)};
        end
      end
    end
  end

  assign filas     = filas_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_module_keypad_scan.sv
// Scoreboard bench for the keypad scanner driven by a behavioural 4x4 key matrix.
module tb_module_keypad_scan;

  localparam int SETTLE = 4;
  localparam int DB     = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  columnas;
  logic [3:0]  filas;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ack = 1'b0;
  logic        key_held;
  logic        overrun;

  logic [15:0] keys = '0;
  logic        bounce_en = 1'b0;
  logic [3:0]  bounce_val = '0;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  bit auto_ack = 1'b1;
  int ack_req = 0;
  int ack_done = 0;

  always #5 clk = ~clk;

  // A closed switch at (r,c) connects row r to column c.
  function automatic logic [3:0] keypad_cols(input logic [3:0] rows, input logic [15:0] k);
    logic [3:0] c;
    c = '0;
    for (int r = 0; r < 4; r++) if (rows[r]) c = c | k[r*4 +: 4];
    return c;
  endfunction

  function automatic int lowest_bit(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return 0;
  endfunction

  assign columnas = bounce_en ? bounce_val : keypad_cols(filas, keys);

  module_keypad_scan #(
    .SETTLE_CYCLES (SETTLE),
    .DB_CYCLES     (DB),
    .CNT_W         (19)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .columnas  (columnas),
    .filas     (filas),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ack   (key_ack),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_held(input logic v, input int bound, input string name);
    int i;
    i = 0;
    while (key_held !== v && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk(name, int'(key_held), int'(v));
  endtask

  task automatic apply_reset(input logic [15:0] k);
    reset = 1'b1;
    keys = k;
    bounce_en = 1'b0;
    cycles(3);
    reset = 1'b0;
  endtask

  task automatic press(input int r, input logic [3:0] pat, input int hold, input bit push);
    if (push) exp_q.push_back(r * 4 + lowest_bit(pat));
    keys = 16'(pat) << (4 * r);
    wait_held(1'b1, 200, "press_detect");
    chk("filas_held", int'(filas), 1 << r);
    cycles(hold);
    chk("held_during", int'(key_held), 1);
    chk("filas_still_held", int'(filas), 1 << r);
    keys = '0;
    wait_held(1'b0, 200, "release_detect");
    chk("filas_after_release", int'(filas), 1);
  endtask

  // Monitor: every key presented is checked against the oldest expected code.
  initial begin
    forever begin
      @(negedge clk);
      key_ack = 1'b0;
      if (!reset && auto_ack && key_valid) begin
        if (exp_q.size() == 0) chk("spurious_key_valid", int'(key_valid), 0);
        else chk("key_code", int'(key_code), exp_q.pop_front());
        key_ack = 1'b1;
      end else if (ack_req != ack_done) begin
        ack_done++;
        key_ack = 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit saw_row0;
    bit saw_held;
    int r;
    logic [3:0] pat;

    // Reset values while reset is held.
    reset = 1'b1;
    cycles(3);
    chk("rst_filas", int'(filas), 1);
    chk("rst_key_valid", int'(key_valid), 0);
    chk("rst_key_code", int'(key_code), 0);
    chk("rst_key_held", int'(key_held), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;

    // Idle scan: each row for SETTLE cycles plus one sample cycle.
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      chk("idle_filas", int'(filas), 1 << ((n / (SETTLE + 1)) % 4));
    end
    chk("idle_key_valid", int'(key_valid), 0);

    // Exact latency from reset with row 0 columns 1 and 3 closed.
    exp_q.push_back(1);
    apply_reset(16'h000A);
    cycles(SETTLE + 1 + DB - 1);
    chk("press_latency_early", int'(key_held), 0);
    cycles(1);
    chk("press_latency_at", int'(key_held), 1);
    chk("press_filas", int'(filas), 1);
    keys = '0;
    cycles(2 + 1 + DB - 1);
    chk("release_latency_early", int'(key_held), 1);
    cycles(1);
    chk("release_latency_at", int'(key_held), 0);

    // Clean press of key 10.
    press(2, 4'b0100, 20, 1'b1);

    // Bouncing contact never produces a key, and scanning carries on.
    r = 0;
    while (filas !== 4'b0010 && r < 100) begin
      @(negedge clk);
      r++;
    end
    chk("bounce_start_row", int'(filas), 2);
    saw_held = 1'b0;
    bounce_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bounce_val = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      if (key_held) saw_held = 1'b1;
    end
    bounce_val = '0;
    bounce_en = 1'b0;
    saw_row0 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (key_held) saw_held = 1'b1;
      if (filas == 4'b0001) saw_row0 = 1'b1;
    end
    chk("bounce_no_held", int'(saw_held), 0);
    chk("bounce_scan_resumes", int'(saw_row0), 1);

    // Randomized single and multi-column presses.
    for (int i = 0; i < 10; i++) begin
      r = int'($urandom_range(0, 3));
      pat = 4'($urandom_range(1, 15));
      press(r, pat, int'($urandom_range(2, 30)), 1'b1);
    end

    // Second press while the first is unconsumed sets overrun.
    auto_ack = 1'b0;
    press(1, 4'b0010, 5, 1'b0);
    chk("ovr_first_valid", int'(key_valid), 1);
    chk("ovr_first_code", int'(key_code), 5);
    chk("ovr_first_flag", int'(overrun), 0);
    press(2, 4'b0010, 5, 1'b0);
    chk("ovr_code_kept", int'(key_code), 5);
    chk("ovr_flag_set", int'(overrun), 1);
    chk("ovr_valid_kept", int'(key_valid), 1);
    ack_req++;
    cycles(3);
    chk("ovr_ack_valid", int'(key_valid), 0);
    chk("ovr_ack_flag", int'(overrun), 0);
    auto_ack = 1'b1;

    // Reset in the middle of debounce discards the press.
    apply_reset(16'h0001);
    cycles(SETTLE + 1 + 8);
    reset = 1'b1;
    cycles(1);
    chk("mid_rst_filas", int'(filas), 1);
    chk("mid_rst_key_valid", int'(key_valid), 0);
    chk("mid_rst_key_held", int'(key_held), 0);
    chk("mid_rst_key_code", int'(key_code), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    keys = '0;
    cycles(2);
    reset = 1'b0;
    saw_held = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (key_held || key_valid) saw_held = 1'b1;
    end
    chk("mid_rst_no_key", int'(saw_held), 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
